// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Fetch stage of the pipeline. Owns the PC register, issues word addresses
//   to a synchronous instruction memory with a 1-cycle read latency, and
//   registers the returned instruction into the IF/ID outputs. A one-entry
//   skid buffer keeps the in-flight word when decode stalls, so no fetched
//   instruction is ever lost or duplicated. A redirect (branch/jump taken)
//   flushes everything in flight and reloads the PC.
//
// Handshake (stall):
//   stall_i=1 means decode cannot accept this cycle: the IF/ID outputs hold
//   their value and no new memory request is issued. A word that was already
//   requested lands in the skid buffer and is presented first once stall_i
//   drops. redirect_i has priority over stall_i.
//
// Optional build macro:
//   IF_MISALIGN_TRAP_EN - adds misalign_o; a redirect target with non-zero
//   low ADDR_LSB bits is aligned down and misalign_o pulses for one cycle.
//
// Ports:
//   clk            in   clock, all state updates on the rising edge
//   reset          in   synchronous active-low reset
//   stall_i        in   decode cannot accept; hold outputs
//   redirect_i     in   branch/jump taken; flush and reload PC
//   redirect_pc_i  in   [B]      new PC when redirect_i=1
//   imem_en_o      out  read request this cycle (combinational)
//   imem_addr_o    out  [MEM_AW] memory word address (combinational)
//   imem_rdata_i   in   [W]      data for the previous cycle's request
//   if_valid_o     out  IF/ID outputs hold a valid instruction
//   if_instr_o     out  [W]      fetched instruction
//   if_pc_o        out  [B]      PC of if_instr_o
//   if_pc_plus_o   out  [B]      if_pc_o + PC_STEP
//   dbg_state_o    out  [2]      FSM state (IDLE=0, FETCH=1, HOLD=2)
//   misalign_o     out  misaligned redirect pulse (IF_MISALIGN_TRAP_EN only)
//
// Parameter constraint: ADDR_LSB + MEM_AW <= B.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int unsigned     B        = 32,
  parameter int unsigned     W        = 32,
  parameter int unsigned     PC_STEP  = 4,
  parameter logic [B-1:0]    RESET_PC = '0,
  parameter int unsigned     ADDR_LSB = 2,
  parameter int unsigned     MEM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [B-1:0]      redirect_pc_i,
  output logic              imem_en_o,
  output logic [MEM_AW-1:0] imem_addr_o,
  input  logic [W-1:0]      imem_rdata_i,
  output logic              if_valid_o,
  output logic [W-1:0]      if_instr_o,
  output logic [B-1:0]      if_pc_o,
  output logic [B-1:0]      if_pc_plus_o,
`ifdef IF_MISALIGN_TRAP_EN
  output logic              misalign_o,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [B-1:0] STEP_B = B'(PC_STEP);

  // State registers
  logic [1:0]   state_q,      state_d;
  logic [B-1:0] pc_q,         pc_d;
  logic         req_valid_q,  req_valid_d;
  logic [B-1:0] req_pc_q,     req_pc_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_instr_q, skid_instr_d;
  logic [B-1:0] skid_pc_q,    skid_pc_d;
  logic         if_valid_q,   if_valid_d;
  logic [W-1:0] if_instr_q,   if_instr_d;
  logic [B-1:0] if_pc_q,      if_pc_d;
  logic [B-1:0] if_pc_plus_q, if_pc_plus_d;
  logic         imem_en;
  logic [B-1:0] target_pc;

`ifdef IF_MISALIGN_TRAP_EN
  // Bits at and above ADDR_LSB; works for ADDR_LSB=0 (mask is all ones).
  localparam logic [B-1:0] ALIGN_MASK = {B{1'b1}} << ADDR_LSB;
  logic misalign_q, misalign_d;
  logic target_misaligned;

  assign target_misaligned = |(redirect_pc_i & ~ALIGN_MASK);
  assign target_pc         = redirect_pc_i & ALIGN_MASK;
`else
  assign target_pc         = redirect_pc_i;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_valid_d  = req_valid_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    if_pc_plus_d = if_pc_plus_q;
    imem_en      = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
    misalign_d   = 1'b0;
`endif

    if (redirect_i) begin
      // Flush: the pending request and the skid entry belong to the wrong
      // path. No request goes out this cycle because pc is being replaced.
      pc_d         = target_pc;
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      if_valid_d   = 1'b0;
      state_d      = ST_FETCH;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_d   = target_misaligned;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end

        ST_FETCH: begin
          if (stall_i) begin
            // The word requested last cycle arrives now; park it so it is
            // not lost while decode is stalled.
            if (req_valid_q) begin
              skid_instr_d = imem_rdata_i;
              skid_pc_d    = req_pc_q;
              skid_valid_d = 1'b1;
              req_valid_d  = 1'b0;
            end
            state_d = ST_HOLD;
          end else begin
            imem_en     = 1'b1;
            pc_d        = pc_q + STEP_B;
            req_valid_d = 1'b1;
            req_pc_d    = pc_q;
            if (req_valid_q) begin
              if_instr_d   = imem_rdata_i;
              if_pc_d      = req_pc_q;
              if_pc_plus_d = req_pc_q + STEP_B;
              if_valid_d   = 1'b1;
            end else begin
              if_valid_d   = 1'b0;
            end
          end
        end

        ST_HOLD: begin
          if (!stall_i) begin
            if (skid_valid_q) begin
              if_instr_d   = skid_instr_q;
              if_pc_d      = skid_pc_q;
              if_pc_plus_d = skid_pc_q + STEP_B;
              if_valid_d   = 1'b1;
            end else begin
              if_valid_d   = 1'b0;
            end
            skid_valid_d = 1'b0;
            imem_en      = 1'b1;
            pc_d         = pc_q + STEP_B;
            req_valid_d  = 1'b1;
            req_pc_d     = pc_q;
            state_d      = ST_FETCH;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_pc_plus_q <= '0;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      if_pc_plus_q <= if_pc_plus_d;
`ifdef IF_MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign imem_en_o    = imem_en;
  assign imem_addr_o  = pc_q[ADDR_LSB +: MEM_AW];
  assign if_valid_o   = if_valid_q;
  assign if_instr_o   = if_instr_q;
  assign if_pc_o      = if_pc_q;
  assign if_pc_plus_o = if_pc_plus_q;
  assign dbg_state_o  = state_q;
`ifdef IF_MISALIGN_TRAP_EN
  assign misalign_o   = misalign_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Drives the fetch unit with directed scenarios followed by random
// stall/redirect/reset traffic. Instruction memory word n holds n+0x100.
// The reference model tracks the fetch stream at transaction level: the
// next PC to fetch and a queue of PCs whose words have been requested but
// not yet handed to decode.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_en_o;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus_o;
  logic [1:0]  dbg_state_o;
`ifdef IF_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_en_o     (imem_en_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc_plus_o  (if_pc_plus_o),
`ifdef IF_MISALIGN_TRAP_EN
    .misalign_o    (misalign_o),
`endif
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Synchronous instruction memory, 1-cycle read latency.
  initial imem_rdata_i = '0;
  always @(posedge clk)
    if (imem_en_o) imem_rdata_i <= 32'h100 + {22'd0, imem_addr_o};

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];   // PCs requested, not yet delivered to decode
  logic        m_started;  // false only in the cycle right after reset
  logic [31:0] m_pc;       // next PC to fetch
  logic        m_valid;
  logic [31:0] m_out_pc;
  logic        m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h100 + ((pc >> 2) & 32'h3FF);
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst_n, input logic st, input logic rd, input logic [31:0] tgt);
    logic        exp_en;
    logic [31:0] tgt_eff;
    @(negedge clk);
    reset         = rst_n;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    tgt_eff = tgt;
`ifdef IF_MISALIGN_TRAP_EN
    tgt_eff = {tgt[31:2], 2'b00};
`endif
    exp_en = rst_n && !rd && m_started && !st;
    #1;
    if (rst_n) begin
      check("imem_en", {31'd0, imem_en_o}, {31'd0, exp_en});
      if (exp_en) check("imem_addr", {22'd0, imem_addr_o}, {22'd0, m_pc[11:2]});
    end
    @(posedge clk);
    if (!rst_n) begin
      m_started = 1'b0;
      m_pc      = 32'h0;
      exp_q.delete();
      m_valid   = 1'b0;
      m_mis     = 1'b0;
    end else if (rd) begin
      m_pc      = tgt_eff;
      exp_q.delete();
      m_valid   = 1'b0;
      m_started = 1'b1;
      m_mis     = (tgt[1:0] != 2'b00);
    end else begin
      m_mis = 1'b0;
      if (!m_started) begin
        m_started = 1'b1;
      end else if (!st) begin
        if (exp_q.size() > 0) begin
          m_valid  = 1'b1;
          m_out_pc = exp_q.pop_front();
        end else begin
          m_valid  = 1'b0;
        end
        exp_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
    #1;
    check("if_valid", {31'd0, if_valid_o}, {31'd0, m_valid});
    if (!rst_n) begin
      check("rst_instr", if_instr_o, 32'h0);
      check("rst_pc", if_pc_o, 32'h0);
      check("rst_pc_plus", if_pc_plus_o, 32'h0);
    end else if (m_valid) begin
      check("if_pc", if_pc_o, m_out_pc);
      check("if_instr", if_instr_o, mem_word(m_out_pc));
      check("if_pc_plus", if_pc_plus_o, m_out_pc + 32'd4);
    end
`ifdef IF_MISALIGN_TRAP_EN
    check("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b0;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    m_started     = 1'b0;
    m_pc          = 32'h0;
    m_valid       = 1'b0;
    m_out_pc      = 32'h0;
    m_mis         = 1'b0;

    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    // Free run to if_pc=8 with request for 12 pending, then stall 3 cycles.
    run(5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    run(4);

    // Redirect during steady fetch.
    step(1'b1, 1'b0, 1'b1, 32'h40);
    run(4);

    // Fill the skid, then redirect and stall together while in HOLD.
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h80);
    run(4);

    // PC wrap-around through 2^32.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    run(5);

    // Misaligned target.
    step(1'b1, 1'b0, 1'b1, 32'h46);
    run(4);

    // Redirect issued right after reset (in IDLE).
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    run(3);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst, r_st, r_rd;
      logic [31:0] r_tgt;
      r_rst = ($urandom_range(0, 99) >= 2);
      r_st  = ($urandom_range(0, 99) < 30);
      r_rd  = ($urandom_range(0, 99) < 8);
      r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                          : $urandom;
      step(r_rst, r_st, r_rd, r_tgt);
    end
    run(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
